// File: rtl/pc_gen_pkg.sv
// Shared constants, state encoding and alignment helper for the fetch PC generator.
package pc_gen_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned PC_ADDR_W = XLEN;

   typedef enum logic [0:0] {
      StBoot,
      StRun
   } pc_state_e;

   // Mask that clears the byte-offset bits within one instruction.
   function automatic logic [63:0] align_mask(input int unsigned inst_bytes);
      return ~(64'(inst_bytes) - 64'd1);
   endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, single write port.
module pc_btb
   import pc_gen_pkg::*;
#(
   parameter int unsigned ADDR_W     = PC_ADDR_W,
   parameter int unsigned INST_BYTES = 4,
   parameter int unsigned DEPTH      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_lookup_pc,
   output logic              o_hit,
   output logic [ADDR_W-1:0] o_target,
   input  logic              i_upd_valid,
   input  logic [ADDR_W-1:0] i_upd_pc,
   input  logic [ADDR_W-1:0] i_upd_target,
   input  logic              i_upd_taken
);

   localparam int unsigned OFF_W = $clog2(INST_BYTES);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;

   logic [DEPTH-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag [DEPTH];
   logic [ADDR_W-1:0] r_tgt [DEPTH];

   logic [IDX_W-1:0] w_lk_idx, w_upd_idx;
   logic [TAG_W-1:0] w_lk_tag, w_upd_tag;
   logic             w_unused;

   assign w_lk_idx  = i_lookup_pc[OFF_W +: IDX_W];
   assign w_lk_tag  = i_lookup_pc[ADDR_W-1 -: TAG_W];
   assign w_upd_idx = i_upd_pc[OFF_W +: IDX_W];
   assign w_upd_tag = i_upd_pc[ADDR_W-1 -: TAG_W];
   assign w_unused  = ^{i_lookup_pc, i_upd_pc};

   // Reads see pre-edge contents, so a same-cycle update is not forwarded.
   assign o_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
   assign o_target = r_tgt[w_lk_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
      end else if (i_upd_valid) begin
         if (i_upd_taken) begin
            r_valid[w_upd_idx] <= 1'b1;
         end else if (r_tag[w_upd_idx] == w_upd_tag) begin
            r_valid[w_upd_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (i_upd_valid && i_upd_taken) begin
         r_tag[w_upd_idx] <= w_upd_tag;
         r_tgt[w_upd_idx] <= i_upd_target;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with redirect handling.
// Optional BTB prediction is enabled by defining PC_GEN_BTB_EN.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned       ADDR_W     = PC_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
   parameter int unsigned       INST_BYTES = 4,
   parameter int unsigned       BTB_DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              pc_ready_i,
   output logic              pc_valid_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              pred_taken_o,
   input  logic              redir_valid_i,
   input  logic [ADDR_W-1:0] redir_pc_i,
   input  logic              upd_valid_i,
   input  logic [ADDR_W-1:0] upd_pc_i,
   input  logic [ADDR_W-1:0] upd_target_i,
   input  logic              upd_taken_i
);

   localparam logic [ADDR_W-1:0] ALIGN = ADDR_W'(align_mask(INST_BYTES));
   localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INST_BYTES);

   pc_state_e         r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic              r_pend_vld, w_pend_vld_nxt;
   logic [ADDR_W-1:0] r_pend_pc, w_pend_pc_nxt;

   logic              w_accept;
   logic              w_btb_hit;
   logic [ADDR_W-1:0] w_btb_target;

`ifdef PC_GEN_BTB_EN
   pc_btb #(
      .ADDR_W    (ADDR_W),
      .INST_BYTES(INST_BYTES),
      .DEPTH     (BTB_DEPTH)
   ) u_btb (
      .clk         (clk),
      .rst         (rst),
      .i_lookup_pc (r_pc),
      .o_hit       (w_btb_hit),
      .o_target    (w_btb_target),
      .i_upd_valid (upd_valid_i),
      .i_upd_pc    (upd_pc_i),
      .i_upd_target(upd_target_i),
      .i_upd_taken (upd_taken_i)
   );
`else
   logic w_unused;

   assign w_btb_hit    = 1'b0;
   assign w_btb_target = '0;
   assign w_unused     = ^{upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i, 32'(BTB_DEPTH)};
`endif

   assign pc_valid_o   = (r_state == StRun);
   assign pc_o         = r_pc;
   assign pred_taken_o = w_btb_hit & pc_valid_o;
   assign w_accept     = pc_valid_o & pc_ready_i & rdy;

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_pend_vld_nxt = r_pend_vld;
      w_pend_pc_nxt  = r_pend_pc;
      if (rdy) begin
         w_state_nxt    = StRun;
         w_pend_vld_nxt = 1'b0;
         // A live redirect is newer than any pending one, so it wins.
         if (redir_valid_i) begin
            w_pc_nxt = redir_pc_i & ALIGN;
         end else if (r_pend_vld) begin
            w_pc_nxt = r_pend_pc;
         end else if (w_accept && pred_taken_o) begin
            w_pc_nxt = w_btb_target;
         end else if (w_accept) begin
            w_pc_nxt = r_pc + STEP;
         end
      end else if (redir_valid_i) begin
         w_pend_vld_nxt = 1'b1;
         w_pend_pc_nxt  = redir_pc_i & ALIGN;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= StBoot;
         r_pc       <= RESET_VEC;
         r_pend_vld <= 1'b0;
         r_pend_pc  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         r_pend_pc  <= w_pend_pc_nxt;
      end
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch front end. It holds the current fetch address and presents it to instruction fetch over a valid/ready handshake. It advances by a configurable instruction size and accepts redirects from execute. An optional branch target buffer supplies predicted next-PCs. It sits between the pipeline control (rdy, redirect from EX) and the IF stage.

## Interface
- `ADDR_W`, 32, PC width in bits.
- `RESET_VEC`, 0, PC value after reset; must be aligned to `INST_BYTES`.
- `INST_BYTES`, 4, sequential step; a power of two, 1 to 8.
- `BTB_DEPTH`, 16, BTB entries; a power of two. Used only with `PC_GEN_BTB_EN`.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global run enable. When low, all state is frozen except BTB writes and latching of redirects.
- `pc_ready_i` in 1: IF accepts the presented PC.
- `pc_valid_o` out 1: PC presented is valid.
- `pc_o` out `ADDR_W`: current fetch PC.
- `pred_taken_o` out 1: `pc_o` hit the BTB, and the next PC is the predicted target.
- `redir_valid_i` in 1: EX redirect request.
- `redir_pc_i` in `ADDR_W`: redirect target.
- `upd_valid_i` in 1: BTB update strobe.
- `upd_pc_i` in `ADDR_W`: branch PC to update.
- `upd_target_i` in `ADDR_W`: resolved branch target.
- `upd_taken_i` in 1: branch resolved taken.

## Operation
- States: BOOT and RUN. Reset enters BOOT. The first `clk` edge with `rst` high and `rdy` high moves to RUN. There is no other transition except reset.
- In BOOT: `pc_valid_o`=0 and `pc_o`=`RESET_VEC`.
- In RUN: `pc_valid_o`=1 continuously. The PC is never withdrawn; it is only replaced.
- Accept is `pc_valid_o & pc_ready_i & rdy`. Next-PC selection, in priority order:
  1. Pending or live redirect: the target, with its low log2(`INST_BYTES`) bits forced to 0.
  2. Accept with `pred_taken_o`=1: the BTB target.
  3. Accept: `pc_o`+`INST_BYTES`, modulo 2^`ADDR_W`. Wrap from all-ones to 0 is legal.
  4. Otherwise: hold.
- Redirect with `rdy`=1: applied at that edge, whether or not an accept happens in the same cycle. The accepted PC counts as consumed; IF discards it.
- Redirect with `rdy`=0: the target is latched into a pending register. A later redirect overwrites the pending target (last wins). The pending target is applied at the first edge with `rdy`=1, then cleared.
- Redirect in BOOT: latched as pending, so the first RUN PC is the redirect target rather than `RESET_VEC`.
- Reset mid-operation clears the pending redirect and all BTB valid bits asynchronously.

## Timing
- Reset values: `pc_o`=`RESET_VEC`, `pc_valid_o`=0, `pred_taken_o`=0, pending redirect invalid, BTB fully invalid.
- `pc_o` and `pc_valid_o` are registered.
- `pred_taken_o` is combinational from the registered `pc_o` and the BTB contents, with no input-to-output combinational path.
- Redirect-to-`pc_o` latency: 1 cycle with `rdy` high. With `rdy` low, 1 cycle after `rdy` rises.
- BTB update is written at the edge where `upd_valid_i` is sampled, and is visible to lookup in the next cycle.
- If an update and a lookup hit the same entry in the same cycle, the lookup returns the old contents.

## Configuration
- Macro: `PC_GEN_BTB_EN`.
- Defined: a direct-mapped BTB of `BTB_DEPTH` entries.
  - Index: `pc` bits above the offset. Tag: the remaining upper bits. Each entry holds a valid bit, the tag and the target.
  - Update with `upd_taken_i`=1 writes the entry valid.
  - Update with `upd_taken_i`=0 invalidates the entry on a tag match; otherwise no change.
- Undefined: `pred_taken_o` is tied 0, the `upd_*` inputs are ignored, and no BTB storage is instantiated. Sequential behaviour is otherwise identical.

## Structure
- The shared package holds:
  - the BOOT/RUN state encoding;
  - the alignment-mask derivation from `INST_BYTES`;
  - the `ADDR_W` default, alongside the existing address-length constant.
- One sub-module, `pc_btb`: the lookup and update storage, instantiated only under `PC_GEN_BTB_EN`.

## Test plan
- Reset with `RESET_VEC`=0x100, then release: BOOT for 1 cycle with `pc_valid_o`=0, then `pc_o`=0x100 and valid. With `pc_ready_i`=1 the PC steps 0x104, 0x108.
- `pc_ready_i`=0 for 3 cycles: `pc_o` holds its value and `pc_valid_o` stays 1. Then `ADDR_W`=8, start at PC 0xFC with ready high: the next PC is 0x00 (wrap).
- Redirect to 0x2003 in the same cycle as an accept at 0x40: next `pc_o`=0x2000 (aligned), not 0x44.
- `rdy`=0, with redirects to 0x300 and then 0x400 while stalled: `pc_o` is unchanged. When `rdy` rises, the next `pc_o`=0x400.
- With BTB enabled: update pc 0x80 to target 0x500, taken. Then fetch reaches 0x80: `pred_taken_o`=1 and the next PC is 0x500. A not-taken update for 0x80 clears the entry, and the next visit gives 0x84.
- Assert `rst` low mid-stream with a pending redirect: the outputs return to their reset values immediately. After release, the first PC is `RESET_VEC` and the BTB misses.
